// File: rtl/sr_bank_arbiter_pkg.sv
// sr_bank_arbiter_pkg
//   Shared encodings for the SR bank arbiter.
//   op_e    : requester operation codes (OpA/OpB)
//   state_e : arbiter FSM states
package sr_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    CHECK = 2'b10,
    ACK   = 2'b11
  } state_e;

endpackage

// File: rtl/sr_bank_arbiter_if.sv
// sr_bank_arbiter_if
//   Groups the requester handshakes and the bank drive/readback of the arbiter.
//   slave  : arbiter side (takes requests and Q, drives Ack/Set/Reset/Busy/Err)
//   master : control logic + bank side
interface sr_bank_arbiter_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic             ReqA;
  logic [1:0]       OpA;
  logic [IDX_W-1:0] IdxA;
  logic             AckA;
  logic             ReqB;
  logic [1:0]       OpB;
  logic [IDX_W-1:0] IdxB;
  logic             AckB;
  logic [N-1:0]     Set;
  logic [N-1:0]     Reset;
  logic [N-1:0]     Q;
  logic             Busy;
  logic             Err;

  modport slave (
    input  ReqA, OpA, IdxA, ReqB, OpB, IdxB, Q,
    output AckA, AckB, Set, Reset, Busy, Err
  );

  modport master (
    output ReqA, OpA, IdxA, ReqB, OpB, IdxB, Q,
    input  AckA, AckB, Set, Reset, Busy, Err
  );
endinterface

// File: rtl/sr_bank_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter.
//   clk, rst_n : clock, async active-low reset (pointer -> side 0)
//   i_req      : request vector {B, A}
//   i_accept   : current grant is being taken this cycle
//   o_grant    : one-hot grant {B, A}
// The pointer names the side that wins a tie. It only moves when both sides
// were requesting and the grant is accepted, so a lone requester does not
// steal the next tie-break from the other side.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_ptr;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_accept && (&i_req)) begin
      r_ptr <= ~r_ptr;
    end
  end

endmodule

// File: rtl/sr_flipflop.sv
// sr_flipflop
//   Clocked SR flip-flop cell of the bank.
//   Clock        : rising edge
//   Preset/Clear : async active-high, Clear dominates
//   Set/Reset    : synchronous; both high holds state
//   Q/Qbar       : state and its complement
module sr_flipflop (
  input  logic Clock,
  input  logic Preset,
  input  logic Clear,
  input  logic Set,
  input  logic Reset,
  output logic Q,
  output logic Qbar
);

  always_ff @(posedge Clock or posedge Preset or posedge Clear) begin
    if (Clear) begin
      Q <= 1'b0;
    end else if (Preset) begin
      Q <= 1'b1;
    end else begin
      case ({Set, Reset})
        2'b10:   Q <= 1'b1;
        2'b01:   Q <= 1'b0;
        default: Q <= Q;
      endcase
    end
  end

  assign Qbar = ~Q;

endmodule

// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter
//   Shares one bank of N SR flip-flops between requesters A and B.
//   Each granted op becomes a one-cycle Set or Reset pulse on a single bit,
//   then the bit is read back and a mismatch is reported with the Ack.
//   Clock   : rising-edge clock
//   Clear_n : async active-low reset
//   bus     : requester handshakes, bank Set/Reset/Q, Busy, Err
//
// state | meaning
// IDLE  | sample requests, grant one, latch op/idx/Q[idx]
// DRIVE | one-cycle Set/Reset pulse on the granted bit
// CHECK | compare Q[idx] with the expected value
// ACK   | one-cycle Ack to the granted side, Err valid
module sr_bank_arbiter
  import sr_bank_arbiter_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic              Clock,
  input  logic              Clear_n,
  sr_bank_arbiter_if.slave  bus
);

  localparam int             LP_CW  = IDX_W + 1;
  localparam logic [LP_CW-1:0] LP_N = LP_CW'(N);
  localparam logic [N-1:0]   LP_ONE = {{(N-1){1'b0}}, 1'b1};

  state_e           r_state;
  state_e           w_state_nxt;
  logic [1:0]       w_req;
  logic [1:0]       w_grant;
  logic             w_accept;
  logic             w_sel_b;
  op_e              w_gnt_op;
  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_gnt_bad;
  logic             w_gnt_q;
  logic [N-1:0]     w_gnt_onehot;
  logic             w_chk_q;
  logic             w_ack;

  logic             r_side;
  logic [IDX_W-1:0] r_idx;
  logic             r_exp;
  logic             r_err;
  logic [N-1:0]     r_set;
  logic [N-1:0]     r_reset;

  assign w_req = {bus.ReqB, bus.ReqA};

  rr_arb2 u_arb (
    .clk      (Clock),
    .rst_n    (Clear_n),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  assign w_sel_b      = w_grant[1];
  assign w_gnt_op     = w_sel_b ? op_e'(bus.OpB) : op_e'(bus.OpA);
  assign w_gnt_idx    = w_sel_b ? bus.IdxB : bus.IdxA;
  assign w_gnt_bad    = {1'b0, w_gnt_idx} >= LP_N;
  assign w_gnt_q      = w_gnt_bad ? 1'b0 : bus.Q[w_gnt_idx];
  assign w_gnt_onehot = LP_ONE << w_gnt_idx;
  assign w_chk_q      = bus.Q[r_idx];

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_accept    = 1'b1;
          w_state_nxt = w_gnt_bad ? ACK : DRIVE;
        end
      end
      DRIVE:   w_state_nxt = CHECK;
      CHECK:   w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Set/Reset are registered at grant so the bank sees a clean pulse that
  // lasts exactly the DRIVE cycle; Clear_n kills it asynchronously.
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      r_side  <= 1'b0;
      r_idx   <= '0;
      r_exp   <= 1'b0;
      r_err   <= 1'b0;
      r_set   <= '0;
      r_reset <= '0;
    end else begin
      r_set   <= '0;
      r_reset <= '0;
      if (w_accept) begin
        r_side <= w_sel_b;
        r_idx  <= w_gnt_idx;
        r_err  <= w_gnt_bad;
        r_exp  <= w_gnt_q;
        if (!w_gnt_bad) begin
          case (w_gnt_op)
            OP_SET: begin
              r_set <= w_gnt_onehot;
              r_exp <= 1'b1;
            end
            OP_RESET: begin
              r_reset <= w_gnt_onehot;
              r_exp   <= 1'b0;
            end
            OP_TOGGLE: begin
              if (w_gnt_q) r_reset <= w_gnt_onehot;
              else         r_set   <= w_gnt_onehot;
              r_exp <= ~w_gnt_q;
            end
            default: r_exp <= w_gnt_q;
          endcase
        end
      end
      if (r_state == CHECK) begin
        r_err <= (w_chk_q != r_exp);
      end
    end
  end

  assign w_ack     = (r_state == ACK);
  assign bus.AckA  = w_ack & ~r_side;
  assign bus.AckB  = w_ack & r_side;
  assign bus.Err   = w_ack & r_err;
  assign bus.Busy  = (r_state != IDLE);
  assign bus.Set   = r_set;
  assign bus.Reset = r_reset;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb_sr_bank_arbiter
//   Directed bench: an 8-bit bank arbiter and a 6-bit one (illegal index case),
//   each driving a bank of sr_flipflop cells whose Q feeds back.
module tb_sr_bank_arbiter;

  logic clk = 1'b0;
  logic clr_n;
  logic mon_en = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  logic [7:0] q8;
  logic [7:0] qb8;
  logic [7:0] stuck0;
  logic [5:0] q6;
  logic [5:0] qb6;

  always #5 clk = ~clk;

  sr_bank_arbiter_if #(.N(8), .IDX_W(3)) bus8 ();
  sr_bank_arbiter_if #(.N(6), .IDX_W(3)) bus6 ();

  sr_bank_arbiter #(.N(8), .IDX_W(3)) u_dut8 (
    .Clock   (clk),
    .Clear_n (clr_n),
    .bus     (bus8.slave)
  );

  sr_bank_arbiter #(.N(6), .IDX_W(3)) u_dut6 (
    .Clock   (clk),
    .Clear_n (clr_n),
    .bus     (bus6.slave)
  );

  for (genvar g = 0; g < 8; g++) begin : g_bank8
    sr_flipflop u_ff (
      .Clock (clk), .Preset (1'b0), .Clear (1'b0),
      .Set (bus8.Set[g]), .Reset (bus8.Reset[g]), .Q (q8[g]), .Qbar (qb8[g])
    );
  end

  for (genvar g = 0; g < 6; g++) begin : g_bank6
    sr_flipflop u_ff (
      .Clock (clk), .Preset (1'b0), .Clear (1'b0),
      .Set (bus6.Set[g]), .Reset (bus6.Reset[g]), .Q (q6[g]), .Qbar (qb6[g])
    );
  end

  // stuck0 lets the bench pin bank bits low as seen by the arbiter
  assign bus8.Q = q8 & ~stuck0;
  assign bus6.Q = q6;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full A-side op on the 8-bit bank with fixed latency checks.
  task automatic run_a(input string tag, input logic [1:0] op, input logic [2:0] idx,
                       input logic [7:0] e_set, input logic [7:0] e_rst, input logic e_err);
    bus8.OpA  = op;
    bus8.IdxA = idx;
    bus8.ReqA = 1'b1;
    tick();
    chk({tag, "_set"}, 32'(bus8.Set), 32'(e_set));
    chk({tag, "_reset"}, 32'(bus8.Reset), 32'(e_rst));
    tick();
    chk({tag, "_early_ack"}, 32'(bus8.AckA), 32'd0);
    tick();
    chk({tag, "_ack"}, 32'(bus8.AckA), 32'd1);
    chk({tag, "_err"}, 32'(bus8.Err), 32'(e_err));
    bus8.ReqA = 1'b0;
    tick();
    chk({tag, "_idle"}, 32'(bus8.Busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("excl8", 32'(bus8.Set & bus8.Reset), 32'd0);
      chk("onehot8", 32'($countones(bus8.Set | bus8.Reset) <= 1), 32'd1);
      chk("ack_both8", 32'(bus8.AckA & bus8.AckB), 32'd0);
      chk("err_noack8", 32'(bus8.Err & ~(bus8.AckA | bus8.AckB)), 32'd0);
      chk("excl6", 32'(bus6.Set & bus6.Reset), 32'd0);
      chk("ack_both6", 32'(bus6.AckA & bus6.AckB), 32'd0);
    end
  end

  initial begin
    clr_n = 1'b1;
    stuck0 = 8'h00;
    bus8.ReqA = 1'b0; bus8.OpA = 2'b00; bus8.IdxA = 3'd0;
    bus8.ReqB = 1'b0; bus8.OpB = 2'b00; bus8.IdxB = 3'd0;
    bus6.ReqA = 1'b0; bus6.OpA = 2'b00; bus6.IdxA = 3'd0;
    bus6.ReqB = 1'b0; bus6.OpB = 2'b00; bus6.IdxB = 3'd0;
    #1 clr_n = 1'b0;
    #1 mon_en = 1'b1;
    tick();
    tick();
    chk("rst_set", 32'(bus8.Set), 32'd0);
    chk("rst_reset", 32'(bus8.Reset), 32'd0);
    chk("rst_acka", 32'(bus8.AckA), 32'd0);
    chk("rst_ackb", 32'(bus8.AckB), 32'd0);
    chk("rst_busy", 32'(bus8.Busy), 32'd0);
    chk("rst_err", 32'(bus8.Err), 32'd0);
    chk("rst_busy6", 32'(bus6.Busy), 32'd0);
    clr_n = 1'b1;
    tick();

    // 1: SET idx 3, Ack three cycles after the request edge
    bus8.OpA = 2'b10; bus8.IdxA = 3'd3; bus8.ReqA = 1'b1;
    tick();
    chk("t1_set", 32'(bus8.Set), 32'h08);
    chk("t1_reset", 32'(bus8.Reset), 32'h00);
    chk("t1_busy", 32'(bus8.Busy), 32'd1);
    tick();
    chk("t1_set_off", 32'(bus8.Set), 32'h00);
    chk("t1_q3", 32'(q8[3]), 32'd1);
    chk("t1_noack", 32'(bus8.AckA), 32'd0);
    tick();
    chk("t1_acka", 32'(bus8.AckA), 32'd1);
    chk("t1_ackb", 32'(bus8.AckB), 32'd0);
    chk("t1_err", 32'(bus8.Err), 32'd0);
    bus8.ReqA = 1'b0;
    tick();
    chk("t1_ack_gone", 32'(bus8.AckA), 32'd0);
    chk("t1_idle", 32'(bus8.Busy), 32'd0);

    // 2: simultaneous requests, pointer at A
    bus8.OpA = 2'b10; bus8.IdxA = 3'd1;
    bus8.OpB = 2'b01; bus8.IdxB = 3'd1;
    bus8.ReqA = 1'b1; bus8.ReqB = 1'b1;
    tick();
    chk("t2_a_set", 32'(bus8.Set), 32'h02);
    chk("t2_a_reset", 32'(bus8.Reset), 32'h00);
    tick();
    chk("t2_q1_hi", 32'(q8[1]), 32'd1);
    tick();
    chk("t2_acka", 32'(bus8.AckA), 32'd1);
    chk("t2_ackb_wait", 32'(bus8.AckB), 32'd0);
    bus8.ReqA = 1'b0;
    tick();
    chk("t2_gap_busy", 32'(bus8.Busy), 32'd0);
    tick();
    chk("t2_b_reset", 32'(bus8.Reset), 32'h02);
    chk("t2_b_set", 32'(bus8.Set), 32'h00);
    tick();
    tick();
    chk("t2_ackb", 32'(bus8.AckB), 32'd1);
    chk("t2_errb", 32'(bus8.Err), 32'd0);
    bus8.ReqB = 1'b0;
    tick();
    chk("t2_q1_lo", 32'(q8[1]), 32'd0);

    // 2b: second tie goes to B first
    bus8.OpA = 2'b10; bus8.IdxA = 3'd0;
    bus8.OpB = 2'b10; bus8.IdxB = 3'd6;
    bus8.ReqA = 1'b1; bus8.ReqB = 1'b1;
    tick();
    chk("t2b_b_set", 32'(bus8.Set), 32'h40);
    tick();
    tick();
    chk("t2b_ackb", 32'(bus8.AckB), 32'd1);
    chk("t2b_acka_wait", 32'(bus8.AckA), 32'd0);
    bus8.ReqB = 1'b0;
    tick();
    tick();
    chk("t2b_a_set", 32'(bus8.Set), 32'h01);
    tick();
    tick();
    chk("t2b_acka", 32'(bus8.AckA), 32'd1);
    bus8.ReqA = 1'b0;
    tick();

    // 3: clear idx 5, then toggle it twice
    run_a("t3_clr", 2'b01, 3'd5, 8'h00, 8'h20, 1'b0);
    run_a("t3_tg1", 2'b11, 3'd5, 8'h20, 8'h00, 1'b0);
    chk("t3_q5_hi", 32'(q8[5]), 32'd1);
    run_a("t3_tg2", 2'b11, 3'd5, 8'h00, 8'h20, 1'b0);
    chk("t3_q5_lo", 32'(q8[5]), 32'd0);

    // 4: N=6 bank, index 7 is illegal
    bus6.OpB = 2'b10; bus6.IdxB = 3'd7; bus6.ReqB = 1'b1;
    tick();
    chk("t4_ackb", 32'(bus6.AckB), 32'd1);
    chk("t4_err", 32'(bus6.Err), 32'd1);
    chk("t4_set", 32'(bus6.Set), 32'h00);
    chk("t4_reset", 32'(bus6.Reset), 32'h00);
    bus6.ReqB = 1'b0;
    tick();
    chk("t4_ack_gone", 32'(bus6.AckB), 32'd0);
    chk("t4_err_gone", 32'(bus6.Err), 32'd0);
    chk("t4_idle", 32'(bus6.Busy), 32'd0);

    // 5: readback mismatch on a bit stuck at 0
    stuck0 = 8'h04;
    run_a("t5_stuck", 2'b10, 3'd2, 8'h04, 8'h00, 1'b1);
    stuck0 = 8'h00;

    // 6: Clear_n during DRIVE after a tie that moved the pointer to B
    bus8.OpA = 2'b10; bus8.IdxA = 3'd4;
    bus8.OpB = 2'b01; bus8.IdxB = 3'd7;
    bus8.ReqA = 1'b1; bus8.ReqB = 1'b1;
    tick();
    chk("t6_drive", 32'(bus8.Set), 32'h10);
    #2 clr_n = 1'b0;
    #1;
    chk("t6_abort_set", 32'(bus8.Set), 32'h00);
    chk("t6_abort_reset", 32'(bus8.Reset), 32'h00);
    chk("t6_abort_busy", 32'(bus8.Busy), 32'd0);
    tick();
    chk("t6_noack_a", 32'(bus8.AckA), 32'd0);
    chk("t6_noack_b", 32'(bus8.AckB), 32'd0);
    clr_n = 1'b1;
    tick();
    chk("t6_regrant_set", 32'(bus8.Set), 32'h10);
    chk("t6_regrant_reset", 32'(bus8.Reset), 32'h00);
    tick();
    tick();
    chk("t6_acka", 32'(bus8.AckA), 32'd1);
    bus8.ReqA = 1'b0;
    tick();
    tick();
    chk("t6_b_reset", 32'(bus8.Reset), 32'h80);
    tick();
    tick();
    chk("t6_ackb", 32'(bus8.AckB), 32'd1);
    bus8.ReqB = 1'b0;
    tick();
    tick();

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
